// File: rtl/xu_add_arb_pkg.sv
// Shared types and adder arithmetic for the XU add arbiter.
// Structs are sized for the widest supported configuration; narrower lanes zero-extend.
package xu_add_arb_pkg;

    localparam int XU_GPR_MAX = 64;
    localparam int XU_INV_MAX = XU_GPR_MAX / 8;
    localparam int XU_TAG_MAX = 8;

    typedef struct packed {
        logic [XU_GPR_MAX-1:0] rs1;
        logic [XU_GPR_MAX-1:0] rs2;
        logic [XU_INV_MAX-1:0] inv;
        logic                  ci;
        logic                  is64;
        logic [XU_TAG_MAX-1:0] tag;
        logic                  src;
    } add_op_t;

    typedef struct packed {
        logic [XU_GPR_MAX-1:0] rt;
        logic                  ovf;
        logic                  ca;
        logic [XU_TAG_MAX-1:0] tag;
        logic                  src;
    } add_res_t;

    typedef enum logic {
        RR_P0 = 1'b0,
        RR_P1 = 1'b1
    } rr_state_t;

    // narrow=1 models a 32-bit GPR build: inv repeats every 4 bits and 64b mode acts as 32b.
    function automatic add_res_t add_calc(input add_op_t op, input logic narrow);
        add_res_t              r;
        logic [XU_GPR_MAX-1:0] x;
        logic [XU_GPR_MAX-1:0] b;
        logic [XU_GPR_MAX:0]   s;
        logic [2:0]            idx;
        logic                  wide;
        logic                  c32;
        logic                  sx;
        logic                  sb;
        logic                  ss;
        for (int k = 0; k < XU_GPR_MAX; k++) begin
            idx = 3'(k);
            if (narrow) idx[2] = 1'b0;
            x[k] = op.rs1[k] ^ op.inv[idx];
        end
        b = op.rs2;
        if (narrow) begin
            x[XU_GPR_MAX-1:32] = '0;
            b[XU_GPR_MAX-1:32] = '0;
        end
        s    = {1'b0, x} + {1'b0, b} + {{XU_GPR_MAX{1'b0}}, op.ci};
        // carry into the upper word is recovered from the sum bit and its two addend bits
        c32  = s[32] ^ x[32] ^ b[32];
        wide = op.is64 & ~narrow;
        sx   = wide ? x[63] : x[31];
        sb   = wide ? b[63] : b[31];
        ss   = wide ? s[63] : s[31];
        r.rt  = s[XU_GPR_MAX-1:0];
        r.ovf = (sx == sb) & (ss != sx);
        r.ca  = wide ? s[XU_GPR_MAX] : c32;
        r.tag = op.tag;
        r.src = op.src;
        return r;
    endfunction

endpackage

// File: rtl/xu_add_arb_rr.sv
// Two-way round-robin grant; the pointer names the requester that wins a tie.
//   state | meaning
//   RR_P0 | requester 0 wins when both request
//   RR_P1 | requester 1 wins when both request
module xu_add_arb_rr
    import xu_add_arb_pkg::*;
(
    input  logic       nclk,
    input  logic       rst,
    input  logic [1:0] req_val,
    input  logic       en,
    output logic [1:0] gnt
);

    rr_state_t state;
    rr_state_t state_nxt;

    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            state <= RR_P0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        gnt       = 2'b00;
        state_nxt = state;
        if (en) begin
            case (req_val)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (state == RR_P0) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0]) begin
            state_nxt = RR_P1;
        end else if (gnt[1]) begin
            state_nxt = RR_P0;
        end
    end

endmodule

// File: rtl/xu_add_arb.sv
// Arbitrates ALU issue and EA path onto one shared adder: stage A holds operands,
// stage B holds the registered result until the consumer takes it.
module xu_add_arb
    import xu_add_arb_pkg::*;
#(
    parameter int GPR_WIDTH = 64,
    parameter int TAG_WIDTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     nclk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               req_val,
    output logic [1:0]               req_rdy,
    input  logic [2*GPR_WIDTH-1:0]   req_rs1,
    input  logic [2*GPR_WIDTH-1:0]   req_rs2,
    input  logic [2*GPR_WIDTH/8-1:0] req_inv,
    input  logic [1:0]               req_ci,
    input  logic [1:0]               req_64b,
    input  logic [2*TAG_WIDTH-1:0]   req_tag,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic                     out_src,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic [GPR_WIDTH-1:0]     out_rt,
    output logic                     out_ovf,
    output logic                     out_ca,
    output logic [CNT_WIDTH-1:0]     conflict_cnt
);

    localparam int INV_WIDTH = GPR_WIDTH / 8;
    localparam bit NARROW    = (GPR_WIDTH == 32);

    add_op_t    lane_op [2];
    add_op_t    sel_op;
    add_op_t    a_op;
    add_res_t   b_res;
    logic       a_val;
    logic       b_val;
    logic       b_free;
    logic       a_move;
    logic       a_free;
    logic       grant;
    logic [1:0] gnt;
    logic       unused_res;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane_op[i]                     = '0;
            lane_op[i].rs1[GPR_WIDTH-1:0]  = req_rs1[i*GPR_WIDTH +: GPR_WIDTH];
            lane_op[i].rs2[GPR_WIDTH-1:0]  = req_rs2[i*GPR_WIDTH +: GPR_WIDTH];
            lane_op[i].inv[INV_WIDTH-1:0]  = req_inv[i*INV_WIDTH +: INV_WIDTH];
            lane_op[i].ci                  = req_ci[i];
            lane_op[i].is64                = req_64b[i];
            lane_op[i].tag[TAG_WIDTH-1:0]  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            lane_op[i].src                 = (i == 1);
        end
    end

    // B frees up in the same cycle it is popped, so a full pipe still accepts on a pop.
    assign b_free = ~b_val | out_rdy;
    assign a_move = a_val & b_free;
    assign a_free = ~a_val | a_move;

    xu_add_arb_rr u_rr (
        .nclk    (nclk),
        .rst     (rst),
        .req_val (req_val),
        .en      (a_free & ~flush & ~rst),
        .gnt     (gnt)
    );

    assign req_rdy = gnt;
    assign grant   = |gnt;
    assign sel_op  = gnt[1] ? lane_op[1] : lane_op[0];

    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            a_val <= 1'b0;
            a_op  <= '0;
        end else begin
            if (flush) begin
                a_val <= 1'b0;
            end else if (grant) begin
                a_val <= 1'b1;
            end else if (a_move) begin
                a_val <= 1'b0;
            end
            if (grant) begin
                a_op <= sel_op;
            end
        end
    end

    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            b_val <= 1'b0;
            b_res <= '0;
        end else begin
            if (flush) begin
                b_val <= 1'b0;
            end else if (b_free) begin
                b_val <= a_val;
            end
            if (a_move) begin
                b_res <= add_calc(a_op, NARROW);
            end
        end
    end

    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if ((req_val == 2'b11) && !(&conflict_cnt)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign out_val = b_val;
    assign out_src = b_res.src;
    assign out_tag = b_res.tag[TAG_WIDTH-1:0];
    assign out_rt  = b_res.rt[GPR_WIDTH-1:0];
    assign out_ovf = b_res.ovf;
    assign out_ca  = b_res.ca;

    // upper struct bits are unused in narrow builds
    assign unused_res = ^{b_res.rt, b_res.tag};

endmodule

// File: tb/tb_xu_add_arb.sv
// Randomized and directed bench for xu_add_arb against a plain-arithmetic reference model.
module tb_xu_add_arb;

    logic         nclk = 1'b0;
    logic         rst;
    logic         flush;
    logic [1:0]   req_val;
    logic [1:0]   req_rdy;
    logic [127:0] req_rs1;
    logic [127:0] req_rs2;
    logic [15:0]  req_inv;
    logic [1:0]   req_ci;
    logic [1:0]   req_64b;
    logic [7:0]   req_tag;
    logic         out_val;
    logic         out_rdy;
    logic         out_src;
    logic [3:0]   out_tag;
    logic [63:0]  out_rt;
    logic         out_ovf;
    logic         out_ca;
    logic [15:0]  conflict_cnt;

    xu_add_arb #(.GPR_WIDTH(64), .TAG_WIDTH(4), .CNT_WIDTH(16)) dut (
        .nclk         (nclk),
        .rst          (rst),
        .flush        (flush),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_inv      (req_inv),
        .req_ci       (req_ci),
        .req_64b      (req_64b),
        .req_tag      (req_tag),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_src      (out_src),
        .out_tag      (out_tag),
        .out_rt       (out_rt),
        .out_ovf      (out_ovf),
        .out_ca       (out_ca),
        .conflict_cnt (conflict_cnt)
    );

    always #5 nclk = ~nclk;

    typedef struct packed {
        logic [63:0] rt;
        logic        ovf;
        logic        ca;
        logic [3:0]  tag;
        logic        src;
    } res_t;

    res_t        exp_q[$];
    res_t        got_q[$];
    int          gnt_q[$];
    int          total = 0;
    int          bad = 0;
    int          arb_err = 0;
    int          last_win = 1;
    logic [15:0] cc_model = 16'd0;
    logic [1:0]  last_rdy;

    logic [63:0] t_rs1 [4] = '{64'd1, 64'd5, 64'd3, 64'd0};
    logic [63:0] t_rs2 [4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd3, 64'd5, 64'h0000_0000_FFFF_FFFF};
    logic [7:0]  t_inv [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    logic        t_ci  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        t_64  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] t_rt  [4] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0001_0000_0000};
    logic        t_ovf [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        t_ca  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    // Reference: true sum, and overflow as "signed result does not fit the mode width".
    function automatic res_t ref_calc(input logic [63:0] a, input logic [63:0] b,
                                      input logic [7:0] inv, input logic ci, input logic is64,
                                      input logic [3:0] tag, input logic src);
        res_t        r;
        logic [63:0] x;
        logic [64:0] full;
        logic [32:0] lo;
        logic [65:0] s64;
        logic [33:0] s32;
        x    = a ^ {8{inv}};
        full = {1'b0, x} + {1'b0, b} + {64'd0, ci};
        lo   = {1'b0, x[31:0]} + {1'b0, b[31:0]} + {32'd0, ci};
        s64  = {{2{x[63]}}, x} + {{2{b[63]}}, b} + {65'd0, ci};
        s32  = {{2{x[31]}}, x[31:0]} + {{2{b[31]}}, b[31:0]} + {33'd0, ci};
        r.rt = full[63:0];
        if (is64) begin
            r.ca  = full[64];
            r.ovf = !(s64[65:63] == 3'b000 || s64[65:63] == 3'b111);
        end else begin
            r.ca  = lo[32];
            r.ovf = !(s32[33:31] == 3'b000 || s32[33:31] == 3'b111);
        end
        r.tag = tag;
        r.src = src;
        return r;
    endfunction

    // One clock: record handshakes and model-side bookkeeping at the falling edge.
    task automatic cyc();
        res_t g;
        @(negedge nclk);
        last_rdy = req_rdy;
        if (!rst) begin
            if ((req_rdy & ~req_val) != 2'b00) arb_err++;
            if (req_rdy == 2'b11) arb_err++;
            for (int i = 0; i < 2; i++) begin
                if (req_val[i] && req_rdy[i]) begin
                    exp_q.push_back(ref_calc(req_rs1[i*64 +: 64], req_rs2[i*64 +: 64],
                                             req_inv[i*8 +: 8], req_ci[i], req_64b[i],
                                             req_tag[i*4 +: 4], (i == 1)));
                    gnt_q.push_back(i);
                    if (req_val == 2'b11 && i == last_win) arb_err++;
                    last_win = i;
                end
            end
            if (out_val && out_rdy) begin
                g.rt  = out_rt;
                g.ovf = out_ovf;
                g.ca  = out_ca;
                g.tag = out_tag;
                g.src = out_src;
                got_q.push_back(g);
            end
            if (req_val == 2'b11 && cc_model != 16'hFFFF) cc_model++;
        end
        @(posedge nclk);
        #1;
    endtask

    task automatic rand_ops();
        req_rs1 = {$urandom, $urandom, $urandom, $urandom};
        req_rs2 = {$urandom, $urandom, $urandom, $urandom};
        req_inv = 16'($urandom);
        req_ci  = 2'($urandom);
        req_64b = 2'($urandom);
        req_tag = 8'($urandom);
    endtask

    task automatic model_reset();
        exp_q.delete();
        got_q.delete();
        gnt_q.delete();
        cc_model = 16'd0;
        last_win = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_val = 2'b11; out_rdy = 1'b0;
        req_rs1 = '0; req_rs2 = '0; req_inv = '0; req_ci = '0; req_64b = '0; req_tag = '0;
        #2;
        total++;
        if (out_val !== 1'b0) begin bad++; $display("FAIL reset_out_val: got %b want 0", out_val); end
        total++;
        if (req_rdy !== 2'b00) begin bad++; $display("FAIL reset_req_rdy: got %b want 00", req_rdy); end
        total++;
        if (conflict_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
        total++;
        if (out_rt !== 64'd0 || out_tag !== 4'd0) begin
            bad++; $display("FAIL reset_data: got rt=%h tag=%h want 0", out_rt, out_tag);
        end
        req_val = 2'b00;
        repeat (2) @(posedge nclk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (req_rdy !== 2'b00) begin bad++; $display("FAIL idle_req_rdy: got %b want 00", req_rdy); end
        req_val = 2'b01;
        #1;
        total++;
        if (req_rdy !== 2'b01) begin bad++; $display("FAIL first_grant: got %b want 01", req_rdy); end
        req_val = 2'b00;
        @(posedge nclk);
        #1;
    endtask

    task automatic test_directed();
        res_t g;
        res_t e;
        out_rdy = 1'b1;
        for (int v = 0; v < 4; v++) begin
            rand_ops();
            req_rs1[63:0] = t_rs1[v];
            req_rs2[63:0] = t_rs2[v];
            req_inv[7:0]  = t_inv[v];
            req_ci[0]     = t_ci[v];
            req_64b[0]    = t_64[v];
            req_tag[3:0]  = 4'(v);
            req_val       = 2'b01;
            cyc();
            req_val = 2'b00;
            total++;
            if (gnt_q.size() != 1) begin bad++; $display("FAIL dir_grant%0d: got %0d grants want 1", v, gnt_q.size()); end
            total++;
            if (out_val !== 1'b0) begin bad++; $display("FAIL dir_lat1_%0d: got out_val=%b want 0", v, out_val); end
            cyc();
            total++;
            if (out_val !== 1'b1) begin bad++; $display("FAIL dir_lat2_%0d: got out_val=%b want 1", v, out_val); end
            cyc();
            total++;
            if (got_q.size() != 1 || exp_q.size() != 1) begin
                bad++; $display("FAIL dir_count%0d: got %0d results want 1", v, got_q.size());
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g.rt !== t_rt[v] || g.ovf !== t_ovf[v] || g.ca !== t_ca[v] || g.src !== 1'b0 || g.tag !== 4'(v)) begin
                    bad++;
                    $display("FAIL dir_vec%0d: got rt=%h ovf=%b ca=%b src=%b tag=%h want rt=%h ovf=%b ca=%b src=0 tag=%h",
                             v, g.rt, g.ovf, g.ca, g.src, g.tag, t_rt[v], t_ovf[v], t_ca[v], 4'(v));
                end
                total++;
                if (g !== e) begin bad++; $display("FAIL dir_model%0d: got %h want %h", v, g, e); end
            end
            exp_q.delete(); got_q.delete(); gnt_q.delete();
        end
    endtask

    task automatic test_alternate();
        res_t g;
        res_t e;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        out_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rand_ops();
            req_tag = 8'h5A;
            req_val = 2'b11;
            cyc();
        end
        req_val = 2'b00;
        repeat (3) cyc();
        total++;
        if (gnt_q.size() != 6) begin
            bad++; $display("FAIL alt_grants: got %0d want 6", gnt_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (gnt_q[k] != (k % 2)) begin
                    bad++; $display("FAIL alt_order%0d: got src %0d want %0d", k, gnt_q[k], k % 2);
                end
            end
        end
        total++;
        if (conflict_cnt !== 16'd6) begin bad++; $display("FAIL alt_cnt: got %0d want 6", conflict_cnt); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL alt_sb_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL alt_sb: got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); gnt_q.delete();
    endtask

    task automatic test_backpressure();
        res_t g;
        res_t e;
        logic [63:0] snap_rt;
        logic [3:0]  snap_tag;
        logic        snap_src;
        out_rdy  = 1'b0;
        snap_rt  = '0;
        snap_tag = '0;
        snap_src = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rand_ops();
            req_val = 2'b01;
            cyc();
            if (c >= 2) begin
                total++;
                if (last_rdy !== 2'b00) begin bad++; $display("FAIL bp_rdy%0d: got %b want 00", c, last_rdy); end
            end
            if (c == 1) begin
                total++;
                if (out_val !== 1'b1) begin bad++; $display("FAIL bp_val: got %b want 1", out_val); end
                snap_rt = out_rt; snap_tag = out_tag; snap_src = out_src;
            end else if (c >= 2) begin
                total++;
                if (out_val !== 1'b1 || out_rt !== snap_rt || out_tag !== snap_tag || out_src !== snap_src) begin
                    bad++; $display("FAIL bp_hold%0d: got val=%b rt=%h tag=%h want val=1 rt=%h tag=%h",
                                    c, out_val, out_rt, out_tag, snap_rt, snap_tag);
                end
            end
        end
        total++;
        if (exp_q.size() != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", exp_q.size()); end
        req_val = 2'b00;
        out_rdy = 1'b1;
        repeat (2) cyc();
        total++;
        if (got_q.size() != 2) begin bad++; $display("FAIL bp_drain: got %0d in 2 cycles want 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL bp_sb: got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); gnt_q.delete();
    endtask

    task automatic test_flush();
        res_t g;
        res_t e;
        logic [15:0] cnt_before;
        out_rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            rand_ops();
            req_val = 2'b01;
            cyc();
        end
        cnt_before = conflict_cnt;
        rand_ops();
        flush   = 1'b1;
        req_val = 2'b11;
        out_rdy = 1'b1;
        cyc();
        flush   = 1'b0;
        req_val = 2'b00;
        total++;
        if (last_rdy !== 2'b00) begin bad++; $display("FAIL flush_no_grant: got %b want 00", last_rdy); end
        total++;
        if (out_val !== 1'b0) begin bad++; $display("FAIL flush_out_val: got %b want 0", out_val); end
        total++;
        if (conflict_cnt !== cnt_before + 16'd1) begin
            bad++; $display("FAIL flush_cnt: got %0d want %0d", conflict_cnt, cnt_before + 16'd1);
        end
        total++;
        if (got_q.size() != 1 || exp_q.size() != 2) begin
            bad++; $display("FAIL flush_pop: got %0d pops %0d accepted want 1 and 2", got_q.size(), exp_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL flush_pop_data: got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); gnt_q.delete();
        cyc();
        total++;
        if (out_val !== 1'b0) begin bad++; $display("FAIL flush_stage_a: got out_val=%b want 0", out_val); end
        rand_ops();
        req_val = 2'b11;
        cyc();
        req_val = 2'b00;
        total++;
        if (gnt_q.size() != 1 || gnt_q[0] != 1) begin
            bad++; $display("FAIL flush_rr: got %0d grants first=%0d want 1 grant to 1",
                            gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[0] : -1);
        end
        repeat (3) cyc();
        total++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL flush_after: got %0d results want 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL flush_after_data: got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); gnt_q.delete();
    endtask

    task automatic test_random();
        res_t g;
        res_t e;
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            req_val = 2'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            cyc();
        end
        req_val = 2'b00;
        out_rdy = 1'b1;
        repeat (4) cyc();
        total++;
        if (arb_err != 0) begin bad++; $display("FAIL rnd_arb: got %0d rule violations want 0", arb_err); end
        total++;
        if (conflict_cnt !== cc_model) begin bad++; $display("FAIL rnd_cnt: got %0d want %0d", conflict_cnt, cc_model); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rnd_sb_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL rnd_sb: got %h want %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); gnt_q.delete();
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            req_val = 2'b11;
            cyc();
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (out_val !== 1'b0) begin bad++; $display("FAIL rstmid_out_val: got %b want 0", out_val); end
        total++;
        if (req_rdy !== 2'b00) begin bad++; $display("FAIL rstmid_req_rdy: got %b want 00", req_rdy); end
        total++;
        if (conflict_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_cnt: got %0d want 0", conflict_cnt); end
        req_val = 2'b00;
        @(posedge nclk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (3) cyc();
        total++;
        if (got_q.size() != 0 || out_val !== 1'b0) begin
            bad++; $display("FAIL rstmid_leak: got %0d results out_val=%b want 0", got_q.size(), out_val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_alternate();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
